prbs31_checker: RTL

PRBS31_CHECKER -- requirements
Module: prbs31_checker

---
 rtl/prbs31_pkg.sv | 18 +
 rtl/prbs31_step.sv | 17 +
 rtl/prbs31_checker.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/prbs31_pkg.sv
// Shared definitions for the PRBS31 checker: polynomial geometry, counter widths
// and the lock FSM state encoding.
package prbs31_pkg;

  localparam int unsigned PrbsWidth   = 31;
  localparam int unsigned PrbsTapHi   = 30;
  localparam int unsigned PrbsTapLo   = 27;
  localparam int unsigned ErrCntWidth = 16;
  localparam int unsigned BitCntWidth = 32;

  // Encoding 3 is never entered; the checker treats it as a return to search.
  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

endpackage

// File: rtl/prbs31_step.sv
// One step of the x^31 + x^28 + 1 recurrence: the predicted next bit plus the two
// candidate next register values (fed with the prediction or with an external bit).
module prbs31_step
  import prbs31_pkg::*;
(
  input  logic [PrbsWidth-1:0] sr,
  input  logic                 shift_bit,
  output logic                 pred_bit,
  output logic [PrbsWidth-1:0] sr_pred,
  output logic [PrbsWidth-1:0] sr_shift
);

  assign pred_bit = sr[PrbsTapHi] ^ sr[PrbsTapLo];
  assign sr_pred  = {sr[PrbsWidth-2:0], pred_bit};
  assign sr_shift = {sr[PrbsWidth-2:0], shift_bit};

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: self-synchronising acquisition, free-running lock with
// windowed loss-of-lock detection, and saturating error / checked-bit counters.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 64,
  parameter int unsigned LOSS_WIN = 128,
  parameter int unsigned LOSS_ERR = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   din,
  input  logic                   din_valid,
  input  logic                   clr_cnt,
  output logic                   locked,
  output logic                   err_pulse,
  output logic [ErrCntWidth-1:0] err_count,
  output logic [BitCntWidth-1:0] bit_count,
  output logic [1:0]             state
);

  localparam int unsigned FillW  = $clog2(PrbsWidth);
  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinW   = $clog2(LOSS_WIN + 1);
  localparam int unsigned WerrW  = $clog2(LOSS_ERR + 1);

  localparam logic [FillW-1:0]  FillLast  = FillW'(PrbsWidth - 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
  localparam logic [WinW-1:0]   WinLast   = WinW'(LOSS_WIN - 1);
  localparam logic [WerrW-1:0]  WerrLast  = WerrW'(LOSS_ERR - 1);

  state_e                 state_q, state_d;
  logic [PrbsWidth-1:0]   sr_q, sr_d;
  logic [FillW-1:0]       fill_q, fill_d;
  logic [MatchW-1:0]      match_q, match_d;
  logic [WinW-1:0]        win_q, win_d;
  logic [WerrW-1:0]       werr_q, werr_d;
  logic [ErrCntWidth-1:0] err_count_q, err_count_d;
  logic [BitCntWidth-1:0] bit_count_q, bit_count_d;
  logic                   locked_q, locked_d;
  logic                   err_pulse_q, err_pulse_d;

  logic                 pred;
  logic                 mismatch;
  logic                 to_search;
  logic [PrbsWidth-1:0] sr_free;
  logic [PrbsWidth-1:0] sr_din;

  prbs31_step u_step (
    .sr        (sr_q),
    .shift_bit (din),
    .pred_bit  (pred),
    .sr_pred   (sr_free),
    .sr_shift  (sr_din)
  );

  assign mismatch = din ^ pred;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    err_pulse_d = 1'b0;
    to_search   = 1'b0;

    unique case (state_q)
      StSearch: begin
        if (din_valid) begin
          sr_d = sr_din;
          // Fill saturates on its last value so an all-zero register keeps being retried.
          if (fill_q == FillLast) begin
            if (sr_din != '0) begin
              state_d = StVerify;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + FillW'(1);
          end
        end
      end

      StVerify: begin
        if (din_valid) begin
          sr_d = sr_din;
          if (mismatch || (sr_din == '0)) begin
            to_search = 1'b1;
          end else if (match_q == MatchLast) begin
            state_d = StLocked;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + MatchW'(1);
          end
        end
      end

      StLocked: begin
        if (din_valid) begin
          // Free-running: the prediction, not din, feeds the register while locked.
          sr_d        = sr_free;
          err_pulse_d = mismatch;
          if (mismatch && !(&err_count_q)) begin
            err_count_d = err_count_q + ErrCntWidth'(1);
          end
          if (!(&bit_count_q)) begin
            bit_count_d = bit_count_q + BitCntWidth'(1);
          end
          if (mismatch && (werr_q == WerrLast)) begin
            to_search = 1'b1;
          end else if (sr_free == '0) begin
            to_search = 1'b1;
          end else if (win_q == WinLast) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + WinW'(1);
            werr_d = werr_q + WerrW'(mismatch);
          end
        end
      end

      default: to_search = 1'b1;
    endcase

    if (to_search) begin
      state_d = StSearch;
      sr_d    = '0;
      fill_d  = '0;
      match_d = '0;
      win_d   = '0;
      werr_d  = '0;
    end

    if (clr_cnt) begin
      err_count_d = '0;
      bit_count_d = '0;
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSearch;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;
  assign state     = state_q;

endmodule
